// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Definitions shared by the CPU front end and the control unit:
//     - OPCODE_W and the opcode encodings carried in instr[INSTR_W-1 -: 4]
//     - fetch_state_t, the state encoding of the instruction fetch unit
//   HALTED is used only when the design is built with FETCH_HALT_EN defined.
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_ADD    = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_SUB    = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_AND    = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_OR     = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_HALT   = 4'b1111;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_out_reg.sv
// ----------------------------------------------------------------------------
// fetch_out_reg
//   Valid/ready holding register between fetch and decode.
//   Ports:
//     clk, reset          clock (rising edge) and asynchronous active-high reset
//     load                capture load_instr/load_pc and raise valid
//     load_instr, load_pc word and its address to capture
//     flush               drop the held word; takes priority over load and
//                         over the handshake
//     ready               decode accepts the word while valid is high
//     valid, instr, pc    held word presented to decode
//   instr and pc change only on load, so they stay stable while valid waits
//   for ready.
// ----------------------------------------------------------------------------
module fetch_out_reg #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic               flush,
    input  logic               ready,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   CPU front end: drives the PC, fetches instructions from instruction
//   memory over req/ack and hands them to decode over valid/ready.
//   Ports:
//     clk, reset                 clock (rising edge), async active-high reset
//     imem_req, imem_addr        fetch request (held until ack) and word address
//     imem_ack, imem_rdata       one-cycle ack with the fetched word
//     if_valid, if_ready         handshake towards decode
//     if_instr, if_pc            instruction word and its address
//     if_opcode                  instr[INSTR_W-1 -: 4], for the control unit
//     branch_taken, branch_target  redirect from execute; wins over ack and
//                                  the decode handshake in the same cycle
//   Build option: FETCH_HALT_EN -- after an OP_HALT instruction is accepted by
//   decode the unit stops fetching until reset or a branch redirect.
// ----------------------------------------------------------------------------
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [OPCODE_W-1:0] if_opcode,
    output logic [ADDR_W-1:0]   if_pc,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_addr;
    logic              req;
    logic              discard;

    logic ack_seen;
    logic out_load;
    logic out_flush;

    // An ack only counts against an outstanding request.
    assign ack_seen  = req && imem_ack;
    assign out_load  = (state == FETCH) && ack_seen && !discard && !branch_taken;
    assign out_flush = branch_taken && (state == ISSUE);

    assign imem_req  = req;
    // Latched separately from pc so the address stays put while a redirect
    // moves pc underneath an outstanding request.
    assign imem_addr = req_addr;
    assign if_opcode = if_instr[INSTR_W-1 -: OPCODE_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            req      <= 1'b0;
            discard  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (branch_taken) begin
                        pc <= branch_target;
                        if (req) begin
                            if (imem_ack) begin
                                // Data arriving with the redirect is simply dropped.
                                req     <= 1'b0;
                                discard <= 1'b0;
                            end else begin
                                // The late ack for the old address must be thrown away.
                                discard <= 1'b1;
                            end
                        end
                    end else if (req) begin
                        if (imem_ack) begin
                            req     <= 1'b0;
                            discard <= 1'b0;
                            if (!discard) begin
                                pc    <= pc + ADDR_W'(1);
                                state <= ISSUE;
                            end
                        end
                    end else begin
                        req      <= 1'b1;
                        req_addr <= pc;
                    end
                end

                ISSUE: begin
                    if (branch_taken) begin
                        pc    <= branch_target;
                        state <= FETCH;
                    end else if (if_valid && if_ready) begin
`ifdef FETCH_HALT_EN
                        state <= (if_opcode == OP_HALT) ? HALTED : FETCH;
`else
                        state <= FETCH;
`endif
                    end
                end

`ifdef FETCH_HALT_EN
                HALTED: begin
                    if (branch_taken) begin
                        pc    <= branch_target;
                        state <= FETCH;
                    end
                end
`endif

                default: state <= FETCH;
            endcase
        end
    end

    fetch_out_reg #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (out_load),
        .load_instr(imem_rdata),
        .load_pc   (req_addr),
        .flush     (out_flush),
        .ready     (if_ready),
        .valid     (if_valid),
        .instr     (if_instr),
        .pc        (if_pc)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. The bench plays instruction memory
//   and decode; all stimulus and expected values are written inline.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [15:0] if_instr;
    logic [3:0]  if_opcode;
    logic [7:0]  if_pc;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W  (8),
        .INSTR_W (16),
        .RESET_PC(8'h00)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .if_opcode    (if_opcode),
        .if_pc        (if_pc),
        .branch_taken (branch_taken),
        .branch_target(branch_target)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] instr, input logic [7:0] pc);
        logic [15:0] w;
        w = instr;
        chk({tag, "_valid"},  {31'd0, if_valid}, 32'd1);
        chk({tag, "_instr"},  {16'd0, if_instr}, {16'd0, instr});
        chk({tag, "_opcode"}, {28'd0, if_opcode}, {28'd0, w[15:12]});
        chk({tag, "_pc"},     {24'd0, if_pc}, {24'd0, pc});
        chk({tag, "_req"},    {31'd0, imem_req}, 32'd0);
    endtask

    task automatic wait_req(input int max);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    // Answer the outstanding request after lat cycles with data.
    task automatic serve(input int lat, input logic [15:0] data, input logic [7:0] addr);
        wait_req(8);
        chk("req_addr", {24'd0, imem_addr}, {24'd0, addr});
        for (int i = 1; i < lat; i++) begin
            tick();
            chk("req_hold", {31'd0, imem_req}, 32'd1);
            chk("addr_hold", {24'd0, imem_addr}, {24'd0, addr});
        end
        imem_rdata = data;
        imem_ack   = 1'b1;
        tick();
        imem_ack   = 1'b0;
    endtask

    task automatic handshake();
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        chk("hs_valid_drop", {31'd0, if_valid}, 32'd0);
    endtask

    initial begin
        // reset, then reset again with a request outstanding
        #1;
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", {24'd0, imem_addr}, 32'd0);
        reset = 1'b1;
        #1;
        chk("async_rst_req",   {31'd0, imem_req}, 32'd0);
        chk("async_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("async_rst_instr", {16'd0, if_instr}, 32'd0);
        chk("async_rst_pc",    {24'd0, if_pc}, 32'd0);
        tick();
        reset = 1'b0;
        chk("req_low_before_edge", {31'd0, imem_req}, 32'd0);
        tick();
        chk("rerun_req",  {31'd0, imem_req}, 32'd1);
        chk("rerun_addr", {24'd0, imem_addr}, 32'd0);

        // sequential fetch, mixed memory latency
        serve(1, 16'h0123, 8'h00);
        chk_out("seq0", 16'h0123, 8'h00);
        handshake();
        serve(3, 16'h1456, 8'h01);
        chk_out("seq1", 16'h1456, 8'h01);
        handshake();
        serve(1, 16'h4789, 8'h02);
        chk_out("seq2", 16'h4789, 8'h02);
        handshake();

        // redirect while waiting for ack on 0x03: the late data is dropped
        wait_req(8);
        chk("br_addr3", {24'd0, imem_addr}, 32'h03);
        tick();
        branch_taken  = 1'b1;
        branch_target = 8'h40;
        tick();
        branch_taken  = 1'b0;
        chk("br_req_held",  {31'd0, imem_req}, 32'd1);
        chk("br_addr_held", {24'd0, imem_addr}, 32'h03);
        imem_rdata = 16'hDEAD;
        imem_ack   = 1'b1;
        tick();
        imem_ack   = 1'b0;
        chk("late_ack_dropped", {31'd0, if_valid}, 32'd0);
        chk("late_ack_req_low", {31'd0, imem_req}, 32'd0);

        // target fetch, then backpressure
        serve(1, 16'h5ABC, 8'h40);
        chk_out("br_target", 16'h5ABC, 8'h40);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("bp", 16'h5ABC, 8'h40);
        end
        handshake();
        tick();
        chk("bp_single_xfer_addr", {24'd0, imem_addr}, 32'h41);
        chk("bp_single_xfer_valid", {31'd0, if_valid}, 32'd0);

        // redirect in ISSUE with ready high: flush, no transfer
        serve(1, 16'h2222, 8'h41);
        chk_out("iss", 16'h2222, 8'h41);
        branch_taken  = 1'b1;
        branch_target = 8'hFF;
        if_ready      = 1'b1;
        tick();
        branch_taken  = 1'b0;
        if_ready      = 1'b0;
        chk("iss_flush_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("iss_flush_req",  {31'd0, imem_req}, 32'd1);
        chk("iss_flush_addr", {24'd0, imem_addr}, 32'hFF);

        // wrap from 0xFF to 0x00
        serve(2, 16'h3333, 8'hFF);
        chk_out("wrap", 16'h3333, 8'hFF);
        handshake();

        // ack with no request pending is ignored
        imem_rdata = 16'hBEEF;
        imem_ack   = 1'b1;
        tick();
        imem_ack   = 1'b0;
        chk("stray_ack_valid", {31'd0, if_valid}, 32'd0);
        chk("wrap_req",  {31'd0, imem_req}, 32'd1);
        chk("wrap_addr", {24'd0, imem_addr}, 32'h00);

        // redirect and ack in the same cycle
        imem_rdata    = 16'hAAAA;
        imem_ack      = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 8'h20;
        tick();
        imem_ack      = 1'b0;
        branch_taken  = 1'b0;
        chk("br_ack_valid", {31'd0, if_valid}, 32'd0);
        chk("br_ack_req",   {31'd0, imem_req}, 32'd0);
        tick();
        chk("br_ack_rereq",  {31'd0, imem_req}, 32'd1);
        chk("br_ack_target", {24'd0, imem_addr}, 32'h20);
        serve(1, 16'h6123, 8'h20);
        chk_out("br_ack_fetch", 16'h6123, 8'h20);

        // reset while an instruction is held
        reset = 1'b1;
        #1;
        chk("rst2_valid", {31'd0, if_valid}, 32'd0);
        chk("rst2_instr", {16'd0, if_instr}, 32'd0);
        chk("rst2_pc",    {24'd0, if_pc}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("rst2_req",  {31'd0, imem_req}, 32'd1);
        chk("rst2_addr", {24'd0, imem_addr}, 32'h00);

`ifdef FETCH_HALT_EN
        // HALT at 0x05 stops fetching; a branch restarts it
        tick();
        branch_taken  = 1'b1;
        branch_target = 8'h05;
        tick();
        branch_taken  = 1'b0;
        imem_ack      = 1'b1;
        tick();
        imem_ack      = 1'b0;
        serve(1, 16'hF000, 8'h05);
        chk_out("halt_issue", 16'hF000, 8'h05);
        handshake();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_req",   {31'd0, imem_req}, 32'd0);
            chk("halt_valid", {31'd0, if_valid}, 32'd0);
        end
        branch_taken  = 1'b1;
        branch_target = 8'h10;
        tick();
        branch_taken  = 1'b0;
        wait_req(4);
        chk("halt_resume_addr", {24'd0, imem_addr}, 32'h10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
